// File: rtl/offchip_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : offchip_mem_arbiter_pkg
//  Description : Shared constants for the off-chip line-memory arbiter: line
//                size, FSM state encodings and default watchdog limit.
//  Revision    : 1.0  initial release
// ============================================================================
package offchip_mem_arbiter_pkg;

   localparam int CACHE_LINE_SIZE         = 16;
   localparam int OFFCHIP_ARB_TIMEOUT_DEF = 1024;

   localparam int STATE_W = 2;
   localparam logic [STATE_W-1:0] OFFCHIP_ARB_IDLE    = 2'd0;
   localparam logic [STATE_W-1:0] OFFCHIP_ARB_BUSY    = 2'd1;
   localparam logic [STATE_W-1:0] OFFCHIP_ARB_RELEASE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/offchip_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : offchip_rr_pick
//  Description : Two-way round-robin picker; one-hot grant, the side that was
//                not served last wins a tie.
//  Revision    : 1.0  initial release
// ============================================================================
module offchip_rr_pick (
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = req;
      if (req == 2'b11) begin
         gnt = last ? 2'b01 : 2'b10;
      end
   end

endmodule
`default_nettype wire

// File: rtl/offchip_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : offchip_mem_arbiter
//  Description : Shares one off-chip cache-line port between the ifetch refill
//                (m0) and dcache refill/write-back (m1) paths.
//                Optional watchdog: define OFFCHIP_ARB_TIMEOUT_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module offchip_mem_arbiter
   import offchip_mem_arbiter_pkg::*;
#(
   parameter int LINE_W         = CACHE_LINE_SIZE * 8,
   parameter int ADDR_W         = 32,
   parameter int TIMEOUT_CYCLES = OFFCHIP_ARB_TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_req,
   input  logic [ADDR_W-1:0] m0_addr,
   output logic [LINE_W-1:0] m0_rdata,
   output logic              m0_done,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [LINE_W-1:0] m1_wdata,
   output logic [LINE_W-1:0] m1_rdata,
   output logic              m1_done,
   output logic              offchip_err,
   input  logic [LINE_W-1:0] offchip_mem_data,
   input  logic              offchip_mem_ready,
   output logic [LINE_W-1:0] offchip_mem_wdata,
   output logic              offchip_mem_write_en,
   output logic              offchip_mem_read_en,
   output logic [ADDR_W-1:0] offchip_mem_addr
);

   logic [STATE_W-1:0] r_state;
   logic [STATE_W-1:0] w_state_nxt;
   logic               r_last;      // 1: m1 was served most recently
   logic               r_owner;     // 1: m1 owns the current transaction
   logic [1:0]         w_gnt;
   logic               w_grant;
   logic               w_finish;
   logic               w_capture;
   logic               w_timeout;

   logic [LINE_W-1:0]  r_m0_rdata;
   logic [LINE_W-1:0]  r_m1_rdata;
   logic               r_m0_done;
   logic               r_m1_done;
   logic               r_err;
   logic [LINE_W-1:0]  r_wdata;
   logic [ADDR_W-1:0]  r_addr;
   logic               r_read_en;
   logic               r_write_en;

   offchip_rr_pick u_pick (
      .req  ({m1_req, m0_req}),
      .last (r_last),
      .gnt  (w_gnt)
   );

`ifdef OFFCHIP_ARB_TIMEOUT_EN
   localparam int c_cnt_w = $clog2(TIMEOUT_CYCLES + 1);
   logic [c_cnt_w-1:0] r_tmo_cnt;

   // Counter sits at zero outside BUSY, so it restarts on every BUSY entry.
   always_ff @(posedge clk) begin
      if (!rst || (r_state != OFFCHIP_ARB_BUSY)) begin
         r_tmo_cnt <= '0;
      end else begin
         r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
   end

   assign w_timeout = (r_state == OFFCHIP_ARB_BUSY) && !offchip_mem_ready &&
                      (r_tmo_cnt == c_cnt_w'(TIMEOUT_CYCLES - 1));
`else
   assign w_timeout = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

   // State register
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= OFFCHIP_ARB_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         OFFCHIP_ARB_IDLE:    if (w_grant) w_state_nxt = OFFCHIP_ARB_BUSY;
         OFFCHIP_ARB_BUSY:    if (offchip_mem_ready || w_timeout) w_state_nxt = OFFCHIP_ARB_RELEASE;
         OFFCHIP_ARB_RELEASE: if (!offchip_mem_ready) w_state_nxt = OFFCHIP_ARB_IDLE;
         default:             w_state_nxt = OFFCHIP_ARB_IDLE;
      endcase
   end

   // Output decode; a lingering ready from the previous transfer blocks new grants
   always_comb begin
      w_grant   = (r_state == OFFCHIP_ARB_IDLE) && !offchip_mem_ready && (m0_req || m1_req);
      w_finish  = (r_state == OFFCHIP_ARB_BUSY) && (offchip_mem_ready || w_timeout);
      w_capture = w_finish && offchip_mem_ready && r_read_en;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_last     <= 1'b1;
         r_owner    <= 1'b0;
         r_m0_rdata <= '0;
         r_m1_rdata <= '0;
         r_m0_done  <= 1'b0;
         r_m1_done  <= 1'b0;
         r_err      <= 1'b0;
         r_wdata    <= '0;
         r_addr     <= '0;
         r_read_en  <= 1'b0;
         r_write_en <= 1'b0;
      end else begin
         r_m0_done <= 1'b0;
         r_m1_done <= 1'b0;
         r_err     <= 1'b0;
         if (w_grant) begin
            r_owner    <= w_gnt[1];
            r_addr     <= w_gnt[1] ? m1_addr  : m0_addr;
            r_wdata    <= w_gnt[1] ? m1_wdata : '0;
            r_read_en  <= w_gnt[0] || !m1_we;
            r_write_en <= w_gnt[1] && m1_we;
         end else if (w_finish) begin
            r_read_en  <= 1'b0;
            r_write_en <= 1'b0;
            r_last     <= r_owner;
            r_m0_done  <= !r_owner;
            r_m1_done  <= r_owner;
            r_err      <= w_timeout;
            if (w_capture) begin
               if (r_owner) r_m1_rdata <= offchip_mem_data;
               else         r_m0_rdata <= offchip_mem_data;
            end
         end
      end
   end

   assign m0_rdata             = r_m0_rdata;
   assign m1_rdata             = r_m1_rdata;
   assign m0_done              = r_m0_done;
   assign m1_done              = r_m1_done;
   assign offchip_err          = r_err;
   assign offchip_mem_wdata    = r_wdata;
   assign offchip_mem_addr     = r_addr;
   assign offchip_mem_read_en  = r_read_en;
   assign offchip_mem_write_en = r_write_en;

endmodule
`default_nettype wire

// File: tb/tb_offchip_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_offchip_mem_arbiter
//  Description : Directed, table-driven bench for offchip_mem_arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_offchip_mem_arbiter;

   localparam int LW = 128;
   localparam int AW = 32;
`ifdef OFFCHIP_ARB_TIMEOUT_EN
   localparam int WAIT1 = 5;
`else
   localparam int WAIT1 = 9;
`endif

   localparam logic [LW-1:0] LA = 128'h0000_0000_0000_0000_0020_81b3_0010_0113;
   localparam logic [LW-1:0] LB = 128'hdead_beef_0123_4567_89ab_cdef_cafe_f00d;
   localparam logic [LW-1:0] LC = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
   localparam logic [LW-1:0] LX = 128'hffff_0000_ffff_0000_ffff_0000_ffff_0000;
   localparam logic [LW-1:0] A5 = {16{8'ha5}};

   logic          clk, rst;
   logic          m0_req, m0_done, m1_req, m1_we, m1_done, offchip_err;
   logic [AW-1:0] m0_addr, m1_addr, mem_addr;
   logic [LW-1:0] m0_rdata, m1_rdata, m1_wdata, mem_data, mem_wdata;
   logic          mem_ready, mem_we, mem_re;

   int n_checks = 0;
   int n_errors = 0;

   offchip_mem_arbiter #(.LINE_W(LW), .ADDR_W(AW), .TIMEOUT_CYCLES(8)) dut (
      .clk                  (clk),
      .rst                  (rst),
      .m0_req               (m0_req),
      .m0_addr              (m0_addr),
      .m0_rdata             (m0_rdata),
      .m0_done              (m0_done),
      .m1_req               (m1_req),
      .m1_we                (m1_we),
      .m1_addr              (m1_addr),
      .m1_wdata             (m1_wdata),
      .m1_rdata             (m1_rdata),
      .m1_done              (m1_done),
      .offchip_err          (offchip_err),
      .offchip_mem_data     (mem_data),
      .offchip_mem_ready    (mem_ready),
      .offchip_mem_wdata    (mem_wdata),
      .offchip_mem_write_en (mem_we),
      .offchip_mem_read_en  (mem_re),
      .offchip_mem_addr     (mem_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic          rst, m0, m1, we, rdy;
      logic [LW-1:0] data;
      logic          rd, wr, d0, d1;
      logic [AW-1:0] addr;
      logic [LW-1:0] r0, r1;
   } vec_t;

   vec_t tbl [12];

   task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //            rst m0 m1 we rdy data  rd wr d0 d1 addr    r0  r1
      tbl[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,LX, 1'b0,1'b0,1'b0,1'b0,32'h0,  '0, '0};
      tbl[1]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,LX, 1'b0,1'b0,1'b0,1'b0,32'h0,  '0, '0};
      tbl[2]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,LX, 1'b1,1'b0,1'b0,1'b0,32'h0,  '0, '0};
      tbl[3]  = '{1'b1,1'b1,1'b1,1'b0,1'b1,LA, 1'b0,1'b0,1'b1,1'b0,32'h0,  LA, '0};
      tbl[4]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,LX, 1'b0,1'b0,1'b0,1'b0,32'h0,  LA, '0};
      tbl[5]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,LX, 1'b1,1'b0,1'b0,1'b0,32'h100,LA, '0};
      tbl[6]  = '{1'b1,1'b1,1'b1,1'b0,1'b1,LB, 1'b0,1'b0,1'b0,1'b1,32'h100,LA, LB};
      tbl[7]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,LX, 1'b0,1'b0,1'b0,1'b0,32'h100,LA, LB};
      tbl[8]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,LX, 1'b1,1'b0,1'b0,1'b0,32'h0,  LA, LB};
      tbl[9]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,LX, 1'b1,1'b0,1'b0,1'b0,32'h0,  LA, LB};
      tbl[10] = '{1'b1,1'b1,1'b0,1'b0,1'b1,LC, 1'b0,1'b0,1'b1,1'b0,32'h0,  LC, LB};
      tbl[11] = '{1'b1,1'b0,1'b0,1'b0,1'b0,LX, 1'b0,1'b0,1'b0,1'b0,32'h0,  LC, LB};

      rst = 1'b0; m0_req = 1'b0; m1_req = 1'b0; m1_we = 1'b0;
      m0_addr = 32'h0; m1_addr = 32'h100; m1_wdata = '0;
      mem_data = LX; mem_ready = 1'b0;
      #1;

      // Reset, m0-alone style reads and contention with strict alternation
      for (int i = 0; i < 12; i++) begin
         rst = tbl[i].rst; m0_req = tbl[i].m0; m1_req = tbl[i].m1;
         m1_we = tbl[i].we; mem_ready = tbl[i].rdy; mem_data = tbl[i].data;
         cyc();
         chk($sformatf("row%0d read_en", i),  LW'(mem_re),      LW'(tbl[i].rd));
         chk($sformatf("row%0d write_en", i), LW'(mem_we),      LW'(tbl[i].wr));
         chk($sformatf("row%0d m0_done", i),  LW'(m0_done),     LW'(tbl[i].d0));
         chk($sformatf("row%0d m1_done", i),  LW'(m1_done),     LW'(tbl[i].d1));
         chk($sformatf("row%0d err", i),      LW'(offchip_err), '0);
         chk($sformatf("row%0d addr", i),     LW'(mem_addr),    LW'(tbl[i].addr));
         chk($sformatf("row%0d m0_rdata", i), m0_rdata,         tbl[i].r0);
         chk($sformatf("row%0d m1_rdata", i), m1_rdata,         tbl[i].r1);
      end

      // m0 alone, ready rises late
      m0_req = 1'b1; mem_ready = 1'b0; mem_data = LX;
      cyc();
      chk("s1 read_en first", LW'(mem_re), 1);
      for (int k = 0; k < WAIT1; k++) begin
         cyc();
         chk("s1 read_en held", LW'(mem_re), 1);
         chk("s1 no early done", LW'(m0_done), 0);
      end
      mem_ready = 1'b1; mem_data = LA;
      cyc();
      chk("s1 m0_done", LW'(m0_done), 1);
      chk("s1 read_en low", LW'(mem_re), 0);
      chk("s1 m0_rdata", m0_rdata, LA);
      m0_req = 1'b0; mem_ready = 1'b0; mem_data = LX;
      cyc();
      chk("s1 done single", LW'(m0_done), 0);

      // m1 write-back: latched addr/wdata, no read strobe, rdata untouched
      m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h100; m1_wdata = A5;
      cyc();
      m1_addr = 32'hbad0; m1_wdata = LX;
      chk("s2 write_en", LW'(mem_we), 1);
      chk("s2 read_en", LW'(mem_re), 0);
      for (int k = 0; k < 5; k++) begin
         cyc();
         chk("s2 write_en held", LW'(mem_we), 1);
         chk("s2 read_en never", LW'(mem_re), 0);
         chk("s2 addr stable", LW'(mem_addr), LW'(32'h100));
         chk("s2 wdata stable", mem_wdata, A5);
      end
      mem_ready = 1'b1; mem_data = LC;
      cyc();
      chk("s2 m1_done", LW'(m1_done), 1);
      chk("s2 write_en low", LW'(mem_we), 0);
      chk("s2 m1_rdata kept", m1_rdata, LB);
      m1_req = 1'b0; m1_we = 1'b0; mem_ready = 1'b0;
      cyc();

      // ready held high while m0 keeps requesting
      m0_req = 1'b1;
      cyc();
      chk("s3 read_en", LW'(mem_re), 1);
      mem_ready = 1'b1; mem_data = LB;
      cyc();
      chk("s3 m0_done", LW'(m0_done), 1);
      chk("s3 m0_rdata", m0_rdata, LB);
      for (int k = 0; k < 10; k++) begin
         cyc();
         chk("s3 no grant while ready", LW'(mem_re), 0);
         chk("s3 no done while ready", LW'(m0_done), 0);
      end
      mem_ready = 1'b0; mem_data = LX;
      cyc();
      chk("s3 turnaround", LW'(mem_re), 0);
      cyc();
      chk("s3 regrant", LW'(mem_re), 1);
      mem_ready = 1'b1; mem_data = LA;
      cyc();
      chk("s3 second done", LW'(m0_done), 1);
      m0_req = 1'b0; mem_ready = 1'b0;
      cyc();

      // reset while BUSY
      m1_req = 1'b1; m1_addr = 32'h200;
      cyc();
      chk("s4 read_en", LW'(mem_re), 1);
      chk("s4 addr", LW'(mem_addr), LW'(32'h200));
      rst = 1'b0;
      cyc();
      chk("s4 rst read_en", LW'(mem_re), 0);
      chk("s4 rst m1_done", LW'(m1_done), 0);
      chk("s4 rst m1_rdata", m1_rdata, '0);
      chk("s4 rst m0_rdata", m0_rdata, '0);
      chk("s4 rst addr", LW'(mem_addr), '0);
      rst = 1'b1; m1_req = 1'b0; mem_ready = 1'b1; mem_data = LC;
      cyc();
      chk("s4 no done after rst", LW'(m1_done), 0);
      chk("s4 idle with ready", LW'(mem_re), 0);
      mem_ready = 1'b0; m0_req = 1'b1; m1_req = 1'b1; m0_addr = 32'h40;
      cyc();
      chk("s4 m0 first after rst", LW'(mem_addr), LW'(32'h40));
      chk("s4 read_en again", LW'(mem_re), 1);
      mem_ready = 1'b1; mem_data = LC;
      cyc();
      chk("s4 m0_done", LW'(m0_done), 1);
      chk("s4 m0_rdata", m0_rdata, LC);
      m0_req = 1'b0; m1_req = 1'b0; mem_ready = 1'b0;
      cyc();

`ifdef OFFCHIP_ARB_TIMEOUT_EN
      // watchdog abort after 8 busy cycles
      m0_req = 1'b1;
      cyc();
      for (int k = 0; k < 7; k++) begin
         cyc();
         chk("tmo read_en held", LW'(mem_re), 1);
         chk("tmo err quiet", LW'(offchip_err), 0);
      end
      cyc();
      chk("tmo read_en dropped", LW'(mem_re), 0);
      chk("tmo m0_done", LW'(m0_done), 1);
      chk("tmo err", LW'(offchip_err), 1);
      chk("tmo rdata kept", m0_rdata, LC);
      m0_req = 1'b0;
      cyc();
      chk("tmo err single", LW'(offchip_err), 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
